// File: rtl/frame_generator.sv
// Transmit framer: packs FIFO-buffered payload bytes into 12-byte frames
// (2 header bytes + 10 payload bytes) and emits one byte per clock.
module frame_generator #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [7:0]  FILL_BYTE  = 8'h00,
   localparam int         LW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_en,
   input  logic          hdr_sel,
   input  logic          hdr_corrupt,
   input  logic [7:0]    pl_data,
   input  logic          pl_valid,
   output logic          pl_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   output logic [3:0]    tx_byte_position,
   output logic          tx_sof,
   output logic          underrun,
   output logic [LW-1:0] fifo_level
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    pos_q, pos_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          sof_q, sof_d;
   logic          underrun_q, underrun_d;
   logic          sel_q, sel_d;
   logic          corrupt_q, corrupt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic push, pop, fifo_empty, start_frame, payload_step;

   assign fifo_empty = (count_q == '0);
   assign pl_ready   = (count_q != LW'(FIFO_DEPTH));
   assign push       = pl_valid && pl_ready;

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      tx_data_d    = 8'h00;
      tx_valid_d   = 1'b0;
      sof_d        = 1'b0;
      underrun_d   = 1'b0;
      sel_d        = sel_q;
      corrupt_d    = corrupt_q;
      pop          = 1'b0;
      start_frame  = 1'b0;
      payload_step = 1'b0;

      case (state_q)
         IDLE: begin
            pos_d = 4'd0;
            if (tx_en) start_frame = 1'b1;
         end
         HDR0: begin
            state_d    = HDR1;
            pos_d      = 4'd1;
            tx_valid_d = 1'b1;
            tx_data_d  = (sel_q ? 8'hBA : 8'hAF) ^ {7'b0, corrupt_q};
         end
         HDR1: payload_step = 1'b1;
         PAYLOAD: begin
            if (pos_q == 4'd11) begin
               if (tx_en) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = IDLE;
                  pos_d   = 4'd0;
               end
            end else begin
               payload_step = 1'b1;
            end
         end
      endcase

      // Header selection is captured on the edge that emits the first header byte
      if (start_frame) begin
         state_d    = HDR0;
         pos_d      = 4'd0;
         tx_valid_d = 1'b1;
         sof_d      = 1'b1;
         tx_data_d  = hdr_sel ? 8'h55 : 8'hAA;
         sel_d      = hdr_sel;
         corrupt_d  = hdr_corrupt;
      end

      if (payload_step) begin
         state_d    = PAYLOAD;
         pos_d      = (state_q == HDR1) ? 4'd2 : pos_q + 4'd1;
         tx_valid_d = 1'b1;
         if (fifo_empty) begin
            tx_data_d  = FILL_BYTE;
            underrun_d = 1'b1;
         end else begin
            tx_data_d = mem_q[rd_ptr_q];
            pop       = 1'b1;
         end
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (!push && pop) count_d = count_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pos_q      <= 4'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         sof_q      <= 1'b0;
         underrun_q <= 1'b0;
         sel_q      <= 1'b0;
         corrupt_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         sof_q      <= sof_d;
         underrun_q <= underrun_d;
         sel_q      <= sel_d;
         corrupt_q  <= corrupt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= pl_data;
   end

   assign tx_data          = tx_data_q;
   assign tx_valid         = tx_valid_q;
   assign tx_byte_position = pos_q;
   assign tx_sof           = sof_q;
   assign underrun         = underrun_q;
   assign fifo_level       = count_q;

endmodule

// File: tb/tb_frame_generator.sv
// Scoreboard bench for frame_generator: stimulus queues expected frame bytes,
// a negedge monitor compares every valid output byte against the queue.
module tb_frame_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b0;
   logic       hdr_sel = 1'b0;
   logic       hdr_corrupt = 1'b0;
   logic [7:0] pl_data = 8'h77;
   logic       pl_valid = 1'b1;
   logic       pl_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [3:0] tx_byte_position;
   logic       tx_sof;
   logic       underrun;
   logic [4:0] fifo_level;

   frame_generator #(.FIFO_DEPTH(16), .FILL_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .hdr_sel(hdr_sel),
      .hdr_corrupt(hdr_corrupt), .pl_data(pl_data), .pl_valid(pl_valid),
      .pl_ready(pl_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_byte_position(tx_byte_position), .tx_sof(tx_sof),
      .underrun(underrun), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [3:0] pos;
      logic       sof;
      logic       und;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue one frame (or its first nlen bytes): nreal payload bytes counting
   // up from first, the rest are fill bytes flagged as underrun.
   task automatic push_frame(input logic [7:0] h0, input logic [7:0] h1,
                             input logic [7:0] first, input int nreal, input int nlen);
      exp_t e;
      for (int p = 0; p < nlen; p++) begin
         e.pos = 4'(p);
         e.sof = (p == 0);
         e.und = 1'b0;
         if (p == 0)                e.data = h0;
         else if (p == 1)           e.data = h1;
         else if (p - 2 < nreal)    e.data = first + 8'(p - 2);
         else begin
            e.data = 8'h00;
            e.und  = 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   task automatic wait_pos(input int p);
      int n = 0;
      while (!(tx_valid === 1'b1 && tx_byte_position == 4'(p)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_pos: position %0d not reached within 200 cycles", p);
      end
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         pl_valid = 1'b1;
         pl_data  = first + 8'(i);
         @(negedge clk);
      end
      pl_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(tx_valid), 0);
      check({tag, "_data"},  32'(tx_data), 0);
      check({tag, "_pos"},   32'(tx_byte_position), 0);
      check({tag, "_sof"},   32'(tx_sof), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (tx_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h at pos %0d expected no valid byte",
                     tx_data, tx_byte_position);
         end else begin
            e = sb.pop_front();
            check("tx_data",  32'(tx_data), 32'(e.data));
            check("tx_pos",   32'(tx_byte_position), 32'(e.pos));
            check("tx_sof",   32'(tx_sof), 32'(e.sof));
            check("underrun", 32'(underrun), 32'(e.und));
         end
      end
   end

   initial begin
      int c0, c1;

      // Reset with writes attempted throughout
      @(negedge clk);
      @(negedge clk);
      check_idle("rst");
      check("rst_underrun", 32'(underrun), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_ready", 32'(pl_ready), 1);
      rst = 1'b0;
      pl_valid = 1'b0;
      @(negedge clk);

      // Back-to-back frames fed continuously; tx_en dropped mid second frame
      load(8'h01, 10);
      check("load_level", 32'(fifo_level), 10);
      push_frame(8'hAA, 8'hAF, 8'h01, 10, 12);
      push_frame(8'hAA, 8'hAF, 8'h0B, 10, 12);
      tx_en = 1'b1;
      hdr_sel = 1'b0;
      load(8'h0B, 10);
      wait_pos(11);
      wait_pos(5);
      tx_en = 1'b0;
      wait_pos(11);
      @(negedge clk);
      check_idle("after_drop");
      check("after_drop_level", 32'(fifo_level), 0);

      // Header select and corruption, changed mid-frame to apply to the next frame
      push_frame(8'h55, 8'hBA, 8'h00, 0, 12);
      push_frame(8'hAA, 8'hAE, 8'h00, 0, 12);
      push_frame(8'hAA, 8'hAF, 8'h00, 0, 12);
      hdr_sel = 1'b1;
      tx_en = 1'b1;
      wait_pos(4);
      hdr_sel = 1'b0;
      hdr_corrupt = 1'b1;
      @(negedge clk);
      wait_pos(4);
      hdr_corrupt = 1'b0;
      @(negedge clk);
      wait_pos(4);
      tx_en = 1'b0;
      wait_pos(11);
      @(negedge clk);
      check_idle("hdr_end");

      // Underrun: 3 bytes, then fill; frame spacing stays at 12 cycles
      load(8'h01, 3);
      push_frame(8'hAA, 8'hAF, 8'h01, 3, 12);
      push_frame(8'hAA, 8'hAF, 8'h00, 0, 12);
      tx_en = 1'b1;
      wait_pos(0);
      c0 = cyc;
      @(negedge clk);
      wait_pos(0);
      c1 = cyc;
      check("sof_spacing", 32'(c1 - c0), 12);
      wait_pos(5);
      tx_en = 1'b0;
      wait_pos(11);
      @(negedge clk);
      check_idle("und_end");

      // Reset mid-frame abandons the frame and clears the FIFO
      load(8'h01, 6);
      push_frame(8'hAA, 8'hAF, 8'h01, 5, 7);
      tx_en = 1'b1;
      wait_pos(6);
      check("pre_rst_level", 32'(fifo_level), 1);
      rst = 1'b1;
      tx_en = 1'b0;
      @(negedge clk);
      check_idle("mid_rst");
      check("mid_rst_level", 32'(fifo_level), 0);
      check("mid_rst_ready", 32'(pl_ready), 1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_sb", 32'(sb.size()), 0);

      // Full FIFO: 17th byte rejected, then drain
      load(8'h30, 16);
      check("full_level", 32'(fifo_level), 16);
      check("full_ready", 32'(pl_ready), 0);
      pl_valid = 1'b1;
      pl_data  = 8'hEE;
      @(negedge clk);
      pl_valid = 1'b0;
      check("full_level2", 32'(fifo_level), 16);
      push_frame(8'hAA, 8'hAF, 8'h30, 10, 12);
      push_frame(8'hAA, 8'hAF, 8'h3A, 6, 12);
      tx_en = 1'b1;
      wait_pos(5);
      @(negedge clk);
      wait_pos(5);
      tx_en = 1'b0;
      wait_pos(11);
      @(negedge clk);
      check_idle("drain_end");
      check("drain_level", 32'(fifo_level), 0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
